// File: rtl/opalkelly_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : opalkelly_tx_arbiter
//  Purpose  : Round-robin packet arbiter in front of the Opal Kelly pipe
//             sys_tx port. It frames every granted packet as
//             header {HDR_TAG, 4'h0, channel id}, the data words, then a
//             trailer holding the data word count (16-bit, wrapping).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    sys_clk       in   system clock
//    sys_rst_n     in   asynchronous active-low reset
//    ch_valid      in   [NUM_CH]     per-channel word valid
//    ch_last       in   [NUM_CH]     per-channel end of packet (with valid)
//    ch_data       in   [16*NUM_CH]  per-channel data, lane i = [16*i+15:16*i]
//    ch_ready      out  [NUM_CH]     per-channel accept
//    sys_tx_ready  in   pipe accepts a word
//    sys_tx_valid  out  word offered to the pipe
//    sys_tx        out  [16] word to the pipe
//    busy          out  high whenever the FSM is not idle
//    grant_id      out  [4]  current or most recent grant
// ============================================================================
module opalkelly_tx_arbiter #(
  parameter int         NUM_CH  = 4,
  parameter logic [7:0] HDR_TAG = 8'hA5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH-1:0]    ch_last,
  input  logic [16*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]    ch_ready,
  input  logic                 sys_tx_ready,
  output logic                 sys_tx_valid,
  output logic [15:0]          sys_tx,
  output logic                 busy,
  output logic [3:0]           grant_id
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_t;

  localparam logic [3:0] C_PTR_RESET = 4'(NUM_CH - 1);

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  ptr_q,   ptr_d;
  logic [15:0] cnt_q,   cnt_d;

  // Channel signals widened to the full 16-channel id space so that the
  // 4-bit grant can index them directly for any NUM_CH.
  logic [15:0] w_valid_ext;
  logic [15:0] w_last_ext;
  logic [15:0] w_ready_ext;
  logic [15:0] w_data_arr [16];

  assign w_valid_ext = 16'(ch_valid);
  assign w_last_ext  = 16'(ch_last);
  assign ch_ready    = w_ready_ext[NUM_CH-1:0];

  for (genvar i = 0; i < 16; i++) begin : g_lane
    if (i < NUM_CH) begin : g_used
      assign w_data_arr[i] = ch_data[16*i +: 16];
    end else begin : g_unused
      assign w_data_arr[i] = 16'h0000;
    end
  end

  // Round-robin pick: first requester scanning upward from ptr+1, wrapping.
  logic       w_found;
  logic [3:0] w_pick;

  always_comb begin : p_pick
    logic [4:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = {1'b0, ptr_q} + 5'(k);
      if (idx >= 5'(NUM_CH)) begin
        idx = idx - 5'(NUM_CH);
      end
      if (!w_found && w_valid_ext[idx[3:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[3:0];
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= 4'd0;
      ptr_q   <= C_PTR_RESET;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state so an asynchronous reset
  // clears them in the same cycle. The DATA path is a direct mux from the
  // granted lane to the pipe and back.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    sys_tx_valid = 1'b0;
    sys_tx       = 16'h0000;
    w_ready_ext  = 16'h0000;

    unique case (state_q)
      ST_IDLE: begin
        if (w_found) begin
          grant_d = w_pick;
          cnt_d   = 16'd0;
          state_d = ST_HEADER;
        end
      end

      ST_HEADER: begin
        sys_tx_valid = 1'b1;
        sys_tx       = {HDR_TAG, 4'h0, grant_q};
        if (sys_tx_ready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        sys_tx_valid         = w_valid_ext[grant_q];
        sys_tx               = w_data_arr[grant_q];
        w_ready_ext[grant_q] = sys_tx_ready;
        if (w_valid_ext[grant_q] && sys_tx_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (w_last_ext[grant_q]) begin
            state_d = ST_TRAILER;
          end
        end
      end

      ST_TRAILER: begin
        sys_tx_valid = 1'b1;
        sys_tx       = cnt_q;
        if (sys_tx_ready) begin
          ptr_d   = grant_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_opalkelly_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_opalkelly_tx_arbiter
//  Purpose  : Self-checking bench for opalkelly_tx_arbiter (NUM_CH = 4).
//             Cycle table for single packets, then hand-written sequences
//             for rotation, back-pressure/stalls, counter wrap and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_opalkelly_tx_arbiter;

  localparam int NUM_CH = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  ch_valid = '0;
  logic [3:0]  ch_last = '0;
  logic [63:0] ch_data = '0;
  logic [3:0]  ch_ready;
  logic        sys_tx_ready = 1'b1;
  logic        sys_tx_valid;
  logic [15:0] sys_tx;
  logic        busy;
  logic [3:0]  grant_id;

  opalkelly_tx_arbiter #(.NUM_CH(NUM_CH), .HDR_TAG(8'hA5)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .ch_valid     (ch_valid),
    .ch_last      (ch_last),
    .ch_data      (ch_data),
    .ch_ready     (ch_ready),
    .sys_tx_ready (sys_tx_ready),
    .sys_tx_valid (sys_tx_valid),
    .sys_tx       (sys_tx),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Every word the pipe accepts, in order.
  logic [15:0] pipe_q [$];
  always @(negedge sys_clk) begin
    if (sys_rst_n && sys_tx_valid && sys_tx_ready) pipe_q.push_back(sys_tx);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] getw(input int j);
    if (j < pipe_q.size()) return pipe_q[j];
    return 16'hxxxx;
  endfunction

  task automatic do_reset();
    sys_rst_n    = 1'b0;
    ch_valid     = '0;
    ch_last      = '0;
    ch_data      = '0;
    sys_tx_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [1:0]  ch;      // lane carrying data; other lanes get 16'hDEAD
    logic [15:0] data;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_tx;
    logic [3:0]  e_ready;
    logic        e_busy;
    logic [3:0]  e_grant;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int cyc;
    int k;
    int stall;
    int bad;
    int wcnt [4];
    logic [3:0] pend;

    // ch2 3-word packet, then ch1 single-word packet with a held header and
    // ch3 requesting (never granted) during it.
    tbl[0]  = '{4'b0100, 4'b0000, 2'd2, 16'h0010, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd0};
    tbl[1]  = '{4'b0100, 4'b0000, 2'd2, 16'h0010, 1'b1, 1'b1, 16'hA502, 4'b0000, 1'b1, 4'd2};
    tbl[2]  = '{4'b0100, 4'b0000, 2'd2, 16'h0010, 1'b1, 1'b1, 16'h0010, 4'b0100, 1'b1, 4'd2};
    tbl[3]  = '{4'b0100, 4'b0000, 2'd2, 16'h0011, 1'b1, 1'b1, 16'h0011, 4'b0100, 1'b1, 4'd2};
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 16'h0012, 1'b1, 1'b1, 16'h0012, 4'b0100, 1'b1, 4'd2};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 16'h0000, 1'b1, 1'b1, 16'h0003, 4'b0000, 1'b1, 4'd2};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd2};
    tbl[7]  = '{4'b0010, 4'b0010, 2'd1, 16'h0BEE, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd2};
    tbl[8]  = '{4'b1010, 4'b0010, 2'd1, 16'h0BEE, 1'b0, 1'b1, 16'hA501, 4'b0000, 1'b1, 4'd1};
    tbl[9]  = '{4'b1010, 4'b0010, 2'd1, 16'h0BEE, 1'b1, 1'b1, 16'hA501, 4'b0000, 1'b1, 4'd1};
    tbl[10] = '{4'b1010, 4'b0010, 2'd1, 16'h0BEE, 1'b1, 1'b1, 16'h0BEE, 4'b0010, 1'b1, 4'd1};
    tbl[11] = '{4'b0000, 4'b0000, 2'd0, 16'h0000, 1'b1, 1'b1, 16'h0001, 4'b0000, 1'b1, 4'd1};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd1};

    // ---------------- reset state ----------------
    do_reset();
    @(negedge sys_clk);
    chk("rst_tx_valid", 32'(sys_tx_valid), 32'd0);
    chk("rst_tx",       32'(sys_tx),       32'd0);
    chk("rst_ch_ready", 32'(ch_ready),     32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_grant",    32'(grant_id),     32'd0);

    // ---------------- cycle table ----------------
    for (int i = 0; i < 13; i++) begin
      @(posedge sys_clk); #1;
      ch_valid     = tbl[i].valid;
      ch_last      = tbl[i].last;
      ch_data      = {4{16'hDEAD}};
      ch_data[16*tbl[i].ch +: 16] = tbl[i].data;
      sys_tx_ready = tbl[i].rdy;
      @(negedge sys_clk);
      chk($sformatf("vec%0d_tx_valid", i), 32'(sys_tx_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d_tx", i),       32'(sys_tx),       32'(tbl[i].e_tx));
      chk($sformatf("vec%0d_ch_ready", i), 32'(ch_ready),     32'(tbl[i].e_ready));
      chk($sformatf("vec%0d_busy", i),     32'(busy),         32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_grant", i),    32'(grant_id),     32'(tbl[i].e_grant));
    end

    // ---------------- rotation: all channels, 2-word packets ----------------
    do_reset();
    pipe_q.delete();
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    cyc = 0;
    while (pipe_q.size() < 20 && cyc < 300) begin
      @(posedge sys_clk); #1;
      cyc++;
      ch_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        ch_last[i] = (wcnt[i] % 2 == 1);
        ch_data[16*i +: 16] = 16'(i * 256 + wcnt[i]);
      end
      @(negedge sys_clk);
      for (int i = 0; i < 4; i++) if (ch_valid[i] && ch_ready[i]) wcnt[i]++;
    end
    for (int p = 0; p < 5; p++) begin
      int c;
      int o;
      c = p % 4;
      o = p / 4;
      chk($sformatf("rr_p%0d_hdr", p), 32'(getw(4*p)),   32'(16'hA500 | 16'(c)));
      chk($sformatf("rr_p%0d_d0", p),  32'(getw(4*p+1)), 32'(c * 256 + 2 * o));
      chk($sformatf("rr_p%0d_d1", p),  32'(getw(4*p+2)), 32'(c * 256 + 2 * o + 1));
      chk($sformatf("rr_p%0d_trl", p), 32'(getw(4*p+3)), 32'h0002);
    end

    // ---------------- back-pressure + valid stall, ch0 5 words ----------------
    do_reset();
    pipe_q.delete();
    k = 0; stall = 0; cyc = 0;
    while (pipe_q.size() < 7 && cyc < 200) begin
      @(posedge sys_clk); #1;
      cyc++;
      sys_tx_ready = (cyc % 2 == 1);
      if (k < 5) begin
        if (k == 2 && stall < 3) begin
          ch_valid = 4'b0000;
          stall++;
        end else begin
          ch_valid = 4'b0001;
        end
        ch_data[15:0] = 16'(16'h0100 + k);
        ch_last = (k == 4) ? 4'b0001 : 4'b0000;
      end else begin
        ch_valid = 4'b0000;
        ch_last  = 4'b0000;
      end
      @(negedge sys_clk);
      if (ch_valid[0] && ch_ready[0]) k++;
    end
    ch_valid = 4'b0000;
    sys_tx_ready = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("bp_pipe_words", 32'(pipe_q.size()), 32'd7);
    chk("bp_ch_accepts", 32'(k), 32'd5);
    chk("bp_hdr", 32'(getw(0)), 32'hA500);
    for (int j = 0; j < 5; j++) chk($sformatf("bp_d%0d", j), 32'(getw(j + 1)), 32'(16'h0100 + j));
    chk("bp_trl", 32'(getw(6)), 32'h0005);

    // ---------------- 65537-word packet on ch3: counter wrap ----------------
    pipe_q.delete();
    sys_tx_ready = 1'b1;
    k = 0; cyc = 0;
    while (pipe_q.size() < 65539 && cyc < 70000) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (k < 65537) begin
        ch_valid = 4'b1000;
        ch_data[63:48] = 16'(k);
        ch_last = (k == 65536) ? 4'b1000 : 4'b0000;
      end else begin
        ch_valid = 4'b0000;
        ch_last  = 4'b0000;
      end
      @(negedge sys_clk);
      if (ch_valid[3] && ch_ready[3]) k++;
    end
    ch_valid = 4'b0000;
    @(negedge sys_clk);
    chk("wrap_pipe_words", 32'(pipe_q.size()), 32'd65539);
    chk("wrap_hdr", 32'(getw(0)), 32'hA503);
    bad = 0;
    for (int j = 0; j < 65537; j++) if (getw(j + 1) !== 16'(j)) bad++;
    chk("wrap_data_errs", 32'(bad), 32'd0);
    chk("wrap_trl", 32'(getw(65538)), 32'h0001);

    // ---------------- reset mid-packet ----------------
    // Finish a ch1 packet first so the pointer is no longer at its reset value.
    pipe_q.delete();
    pend = 4'b0010; cyc = 0;
    while (pipe_q.size() < 3 && cyc < 50) begin
      @(posedge sys_clk); #1;
      cyc++;
      ch_valid = pend;
      ch_last  = 4'b0010;
      ch_data[31:16] = 16'h1234;
      @(negedge sys_clk);
      pend = pend & ~(ch_valid & ch_ready);
    end
    ch_valid = 4'b0000;
    chk("pre_rst_ch1_trl", 32'(getw(2)), 32'h0001);

    k = 0; cyc = 0;
    ch_last = 4'b0000;
    while (k < 2 && cyc < 50) begin
      @(posedge sys_clk); #1;
      cyc++;
      ch_valid = 4'b0100;
      ch_data[47:32] = 16'(16'h0200 + k);
      @(negedge sys_clk);
      if (ch_valid[2] && ch_ready[2]) k++;
    end
    @(posedge sys_clk); #1;
    ch_data[47:32] = 16'h0202;
    #1;
    chk("rst_mid_pre_valid", 32'(sys_tx_valid), 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", 32'(sys_tx_valid), 32'd0);
    chk("rst_mid_ch_ready", 32'(ch_ready),     32'd0);
    chk("rst_mid_busy",     32'(busy),         32'd0);
    chk("rst_mid_tx",       32'(sys_tx),       32'd0);
    ch_valid = 4'b0000;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pipe_q.delete();

    pend = 4'b1001; cyc = 0;
    ch_last = 4'b1001;
    ch_data[15:0]  = 16'h00C0;
    ch_data[63:48] = 16'h03C3;
    while (pipe_q.size() < 6 && cyc < 100) begin
      @(posedge sys_clk); #1;
      cyc++;
      ch_valid = pend;
      @(negedge sys_clk);
      if (cyc == 2) begin
        chk("post_rst_grant", 32'(grant_id), 32'd0);
        chk("post_rst_hdr",   32'(sys_tx),   32'hA500);
      end
      pend = pend & ~(ch_valid & ch_ready);
    end
    ch_valid = 4'b0000;
    chk("post_rst_w0", 32'(getw(0)), 32'hA500);
    chk("post_rst_w1", 32'(getw(1)), 32'h00C0);
    chk("post_rst_w2", 32'(getw(2)), 32'h0001);
    chk("post_rst_w3", 32'(getw(3)), 32'hA503);
    chk("post_rst_w4", 32'(getw(4)), 32'h03C3);
    chk("post_rst_w5", 32'(getw(5)), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
